// File: rtl/mole_round_ctrl.sv
// rtl/mole_round_ctrl.sv - whack-a-mole game round controller
module mole_round_ctrl #(
  parameter int NUM_ROUNDS  = 16,
  parameter int GAP_CYCLES  = 250,
  parameter int SHOW_CYCLES = 1000,
  parameter int SCORE_W     = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [7:0]         btn,
  input  logic [2:0]         gen_state,
  output logic               gen_x,
  output logic               gen_y,
  output logic [7:0]         mole_onehot,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] round_cnt,
  output logic               busy,
  output logic               done,
  output logic               hit_pulse,
  output logic               miss_pulse
);

  // The timer serves both the gap and the show window, so size it for the longer one.
  localparam int MAX_CYC = (GAP_CYCLES > SHOW_CYCLES) ? GAP_CYCLES : SHOW_CYCLES;
  localparam int TW      = $clog2(MAX_CYC + 1);

  localparam logic [TW-1:0]      GAP_LAST    = TW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0]      SHOW_LAST   = TW'(SHOW_CYCLES - 1);
  localparam logic [TW-1:0]      TIMER_ONE   = TW'(1);
  localparam logic [SCORE_W-1:0] ROUNDS_LAST = SCORE_W'(NUM_ROUNDS - 1);
  localparam logic [SCORE_W-1:0] CNT_ONE     = SCORE_W'(1);
  localparam logic [SCORE_W-1:0] CNT_MAX     = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GAP,
    S_SHOW,
    S_SCORE,
    S_DONE
  } state_t;

  state_t             state, state_n;
  logic [TW-1:0]      timer, timer_n;
  logic [1:0]         mix;
  logic [7:0]         btn_q;
  logic [7:0]         rise;
  logic [2:0]         pos, pos_n;
  logic [2:0]         prev_pos, prev_pos_n;
  logic               prev_valid, prev_valid_n;
  logic [SCORE_W-1:0] score_n, round_n;
  logic [7:0]         mole_n;
  logic               hit_n, miss_n;
  logic               busy_n, done_n;

  // Only fresh presses count; a button already down when the mole appears is ignored.
  always_comb begin
    rise = btn & ~btn_q;
  end

  // Free-running stir counter and button history, independent of the game state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mix   <= 2'd0;
      gen_x <= 1'b0;
      gen_y <= 1'b0;
      btn_q <= 8'h00;
    end else begin
      mix            <= mix + 2'd1;
      {gen_x, gen_y} <= mix;
      btn_q          <= btn;
    end
  end

  // State register and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      timer       <= '0;
      pos         <= 3'd0;
      prev_pos    <= 3'd0;
      prev_valid  <= 1'b0;
      score       <= '0;
      round_cnt   <= '0;
      mole_onehot <= 8'h00;
      hit_pulse   <= 1'b0;
      miss_pulse  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_n;
      timer       <= timer_n;
      pos         <= pos_n;
      prev_pos    <= prev_pos_n;
      prev_valid  <= prev_valid_n;
      score       <= score_n;
      round_cnt   <= round_n;
      mole_onehot <= mole_n;
      hit_pulse   <= hit_n;
      miss_pulse  <= miss_n;
      busy        <= busy_n;
      done        <= done_n;
    end
  end

  // Next-state and next-output logic for the round sequence.
  always_comb begin
    state_n      = state;
    timer_n      = timer;
    pos_n        = pos;
    prev_pos_n   = prev_pos;
    prev_valid_n = prev_valid;
    score_n      = score;
    round_n      = round_cnt;
    mole_n       = 8'h00;
    hit_n        = 1'b0;
    miss_n       = 1'b0;

    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          score_n      = '0;
          round_n      = '0;
          prev_valid_n = 1'b0;
          timer_n      = '0;
          state_n      = S_GAP;
        end
      end

      S_GAP: begin
        if (timer == GAP_LAST) begin
          // Stall the gap with the timer frozen until the generator moves off the last mole.
          if (!(prev_valid && (gen_state == prev_pos))) begin
            pos_n   = gen_state;
            timer_n = '0;
            mole_n  = 8'h01 << gen_state;
            state_n = S_SHOW;
          end
        end else begin
          timer_n = timer + TIMER_ONE;
        end
      end

      S_SHOW: begin
        // A hit is checked first so a press on the last show cycle beats the timeout.
        if (rise[pos]) begin
          hit_n   = 1'b1;
          score_n = (score == CNT_MAX) ? score : score + CNT_ONE;
          state_n = S_SCORE;
        end else if (timer == SHOW_LAST) begin
          miss_n  = 1'b1;
          state_n = S_SCORE;
        end else begin
          timer_n = timer + TIMER_ONE;
          mole_n  = mole_onehot;
        end
      end

      S_SCORE: begin
        round_n      = round_cnt + CNT_ONE;
        prev_pos_n   = pos;
        prev_valid_n = 1'b1;
        timer_n      = '0;
        state_n      = (round_cnt == ROUNDS_LAST) ? S_DONE : S_GAP;
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase

    busy_n = (state_n == S_GAP) || (state_n == S_SHOW) || (state_n == S_SCORE);
    done_n = (state_n == S_DONE);
  end

endmodule

// File: tb/tb_mole_round_ctrl.sv
// tb/tb_mole_round_ctrl.sv - randomized self-checking bench for mole_round_ctrl
module tb_mole_round_ctrl;

  localparam int NR = 3;
  localparam int GC = 4;
  localparam int SC = 8;
  localparam int SW = 5;
  localparam int SMAX = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [7:0]    btn = 8'h00;
  logic [2:0]    gen_state = 3'd0;
  logic          gen_x, gen_y;
  logic [7:0]    mole_onehot;
  logic [SW-1:0] score, round_cnt;
  logic          busy, done, hit_pulse, miss_pulse;

  mole_round_ctrl #(
    .NUM_ROUNDS (NR),
    .GAP_CYCLES (GC),
    .SHOW_CYCLES(SC),
    .SCORE_W    (SW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .btn        (btn),
    .gen_state  (gen_state),
    .gen_x      (gen_x),
    .gen_y      (gen_y),
    .mole_onehot(mole_onehot),
    .score      (score),
    .round_cnt  (round_cnt),
    .busy       (busy),
    .done       (done),
    .hit_pulse  (hit_pulse),
    .miss_pulse (miss_pulse)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference state, kept at game/round level.
  int         score_m = 0;
  int         round_m = 0;
  int         prev_pos_m = 0;
  bit         prev_valid_m = 0;
  logic [7:0] exp_mole = 8'h00;
  logic       exp_busy = 1'b0;
  logic       exp_done = 1'b0;
  logic       exp_hit  = 1'b0;
  logic       exp_miss = 1'b0;

  // Clock edges seen since reset was released.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, expv, $time);
    end
  endtask

  task automatic check_all();
    check("mole_onehot", 32'(mole_onehot), 32'(exp_mole));
    check("busy", 32'(busy), 32'(exp_busy));
    check("done", 32'(done), 32'(exp_done));
    check("hit_pulse", 32'(hit_pulse), 32'(exp_hit));
    check("miss_pulse", 32'(miss_pulse), 32'(exp_miss));
    check("score", 32'(score), 32'(score_m));
    check("round_cnt", 32'(round_cnt), 32'(round_m));
    check("gen_xy", 32'({gen_x, gen_y}), (cyc == 0) ? 32'd0 : 32'((cyc - 1) % 4));
  endtask

  task automatic set_exp(input logic [7:0] m, input logic b, input logic d, input logic h, input logic x);
    exp_mole = m;
    exp_busy = b;
    exp_done = d;
    exp_hit  = h;
    exp_miss = x;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle_ticks(input int n);
    start = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic start_game();
    start        = 1'b1;
    score_m      = 0;
    round_m      = 0;
    prev_valid_m = 0;
    set_exp(8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    start = 1'b0;
  endtask

  // One round from the cycle after GAP entry. stall: extra gap cycles with the
  // generator parked on the previous mole. p: show cycle of the press (0 = none).
  // hold: correct button already down before the mole appears. abort: stop after this edge.
  task automatic play_round(input int pos, input int stall, input int p, input bit hold, input int abort);
    int L;
    int endk;
    bit b;
    L    = GC + stall;
    endk = (p != 0) ? L + p : L + SC;
    for (int k = 1; k <= endk + 1; k++) begin
      start = ($urandom_range(0, 3) == 0);
      if (k < GC)       gen_state = 3'($urandom);
      else if (k < L)   gen_state = 3'(prev_pos_m);
      else if (k == L)  gen_state = 3'(pos);
      else              gen_state = 3'($urandom);

      if (k > endk)                               b = 1'b0;
      else if (p != 0 && k >= L + p)              b = 1'b1;
      else if (hold && (p == 0 || k <= L + p - 2)) b = 1'b1;
      else                                        b = 1'b0;
      btn = (8'($urandom) & ~(8'h01 << pos)) | (8'(b) << pos);

      if (k < L) begin
        set_exp(8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
      end else if (k < endk) begin
        set_exp(8'h01 << pos, 1'b1, 1'b0, 1'b0, 1'b0);
      end else if (k == endk) begin
        if (p != 0 && score_m < SMAX) score_m++;
        set_exp(8'h00, 1'b1, 1'b0, p != 0, p == 0);
      end else begin
        round_m++;
        prev_pos_m   = pos;
        prev_valid_m = 1;
        set_exp(8'h00, round_m != NR, round_m == NR, 1'b0, 1'b0);
      end
      tick();
      if (k == abort) begin
        start = 1'b0;
        return;
      end
    end
    start = 1'b0;
  endtask

  task automatic apply_reset();
    #3;
    rst          = 1'b1;
    score_m      = 0;
    round_m      = 0;
    prev_valid_m = 0;
    set_exp(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    check_all();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int pos;
    int stall;
    int p;
    bit hold;

    // Reset state, including through a clock edge.
    set_exp(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    check_all();
    tick();
    rst = 1'b0;
    idle_ticks(3);

    // Game 1: timeout round, hit round, then a stalled gap with a last-cycle hit.
    start_game();
    play_round(5, 0, 0, 1'b0, 0);
    play_round(2, 0, 3, 1'b0, 0);
    play_round(7, 3, SC, 1'b0, 0);
    idle_ticks(3);

    // Game 2 from DONE: three hits on show cycle 3.
    start_game();
    play_round(2, 0, 3, 1'b0, 0);
    play_round(6, 0, 3, 1'b0, 0);
    play_round(1, 0, 3, 1'b0, 0);
    idle_ticks(2);

    // Game 3: held button then re-press, then reset in the middle of a show.
    start_game();
    play_round(2, 0, 5, 1'b1, 0);
    play_round(4, 0, 0, 1'b0, GC + 2);
    apply_reset();
    idle_ticks(2);

    // Randomized games.
    for (int g = 0; g < 8; g++) begin
      start_game();
      for (int r = 0; r < NR; r++) begin
        do pos = $urandom_range(0, 7); while (prev_valid_m && pos == prev_pos_m);
        stall = prev_valid_m ? $urandom_range(0, 3) : 0;
        hold  = 1'($urandom_range(0, 1));
        p     = $urandom_range(0, SC);
        if (hold && p == 1) p = 2;
        play_round(pos, stall, p, hold, 0);
      end
      idle_ticks($urandom_range(1, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
